ro_sense_ctrl: RTL and testbench

Parametrised measurement controller for a ring-oscillator sensor array.
- Samples N free-running, asynchronous oscillator outputs and counts rising edges per channel over a programmable clk-cycle window.
- Sums the masked channels through a pipelined adder tree and accumulates a programmable number of windows.
- Buffers results in a small FIFO drained by a valid/ready handshake.
- Successor to the fixed single-mode ro_top: adds channel mask, variable window, single/continuous modes, output FIFO and an overflow flag.

---
 rtl/ro_pkg.sv | 22 ++
 rtl/ro_add_tree.sv | 52 +++++
 rtl/ro_sense_ctrl.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_ro_sense_ctrl.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_pkg.sv
// ro_pkg: shared types and defaults for the ring-oscillator sense controller.
// Holds the FSM state enum, mode encodings and default parameter values.
package ro_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    COUNT,
    SUM,
    PUSH
  } ro_state_e;

  localparam logic RO_MODE_SINGLE = 1'b0;
  localparam logic RO_MODE_CONT   = 1'b1;

  localparam int RO_N_DEF     = 8;
  localparam int RO_WIDTH_DEF = 16;
  localparam int RO_NSW_DEF   = 3;
  localparam int RO_WINW_DEF  = 16;
  localparam int RO_FIFO_DEF  = 4;

endpackage

// File: rtl/ro_add_tree.sv
// ro_add_tree: pipelined N-input unsigned adder tree, one register per level.
// Ports: clk, rst_n, in_i (N packed WIDTH-bit lanes), in_valid_i, sum_o, valid_o.
module ro_add_tree #(
  parameter  int N     = 8,
  parameter  int WIDTH = 16,
  localparam int LVL   = $clog2(N),
  localparam int OW    = WIDTH + LVL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_i,
  input  logic               in_valid_i,
  output logic [OW-1:0]      sum_o,
  output logic               valid_o
);

  // Heap layout: node i sums children 2i and 2i+1;
  // indices N..2N-1 are the (unregistered) leaves.
  logic [OW-1:0]  node_q [1:N-1];
  logic [OW-1:0]  full   [2:2*N-1];
  logic [LVL-1:0] vld_q;

  always_comb begin
    for (int i = 2; i < N; i++) begin
      full[i] = node_q[i];
    end
    for (int i = 0; i < N; i++) begin
      full[N+i] = OW'(in_i[i*WIDTH +: WIDTH]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < N; i++) begin
        node_q[i] <= '0;
      end
      vld_q <= '0;
    end else begin
      for (int i = 1; i < N; i++) begin
        node_q[i] <= full[2*i] + full[2*i+1];
      end
      vld_q[0] <= in_valid_i;
      for (int l = 1; l < LVL; l++) begin
        vld_q[l] <= vld_q[l-1];
      end
    end
  end

  assign sum_o   = node_q[1];
  assign valid_o = vld_q[LVL-1];

endmodule

// File: rtl/ro_sense_ctrl.sv
// ro_sense_ctrl: ring-oscillator edge counter, masked window sum/accumulate,
// result FIFO with valid/ready drain and sticky overflow.
// Ports: clk, rst_n, go, mode, num_samples, window_cycles, ch_mask, ro_in,
// result, result_valid, result_ready, busy, overflow,
// ch_sat (only when RO_SAT_FLAG_EN is defined: sticky per-channel saturation).
module ro_sense_ctrl
  import ro_pkg::*;
#(
  parameter  int N                = RO_N_DEF,
  parameter  int WIDTH            = RO_WIDTH_DEF,
  parameter  int NUM_SAMPLE_WIDTH = RO_NSW_DEF,
  parameter  int WINDOW_WIDTH     = RO_WINW_DEF,
  parameter  int FIFO_DEPTH       = RO_FIFO_DEF,
  localparam int ACC_WIDTH        = WIDTH + $clog2(N) + NUM_SAMPLE_WIDTH
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        go,
  input  logic                        mode,
  input  logic [NUM_SAMPLE_WIDTH-1:0] num_samples,
  input  logic [WINDOW_WIDTH-1:0]     window_cycles,
  input  logic [N-1:0]                ch_mask,
  input  logic [N-1:0]                ro_in,
  output logic [ACC_WIDTH-1:0]        result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy,
`ifdef RO_SAT_FLAG_EN
  output logic                        overflow,
  output logic [N-1:0]                ch_sat
`else
  output logic                        overflow
`endif
);

  localparam int LVL = $clog2(N);
  localparam int SW  = WIDTH + LVL;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int SCW = $clog2(LVL + 1);

  localparam logic [SCW-1:0]   SUM_LAST = SCW'(LVL - 1);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;

  ro_state_e state_q;

  logic                        go_q;
  logic                        busy_q;
  logic                        ovf_q;
  logic                        mode_q;
  logic [NUM_SAMPLE_WIDTH-1:0] ns_q;
  logic [NUM_SAMPLE_WIDTH-1:0] idx_q;
  logic [WINDOW_WIDTH-1:0]     win_q;
  logic [WINDOW_WIDTH-1:0]     wcnt_q;
  logic [SCW-1:0]              scnt_q;
  logic [N-1:0]                mask_q;

  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] s3_q;
  logic [N-1:0] ro_edge;

  logic [WIDTH-1:0] cnt_q [N];

  logic [N*WIDTH-1:0] tree_in;
  logic               tree_in_vld;
  logic [SW-1:0]      tree_sum;
  logic               tree_vld;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] acc_d;

  logic [ACC_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]          wptr_q;
  logic [AW:0]          rptr_q;

  logic go_start;
  logic cnt_en;
  logic cnt_clr;
  logic win_end;
  logic sum_end;
  logic more_win;
  logic full;
  logic empty;
  logic push;
  logic pop;
  logic push_ok;
  logic drop;

  // Single mode starts on a go edge, continuous on go level.
  assign go_start = (mode == RO_MODE_CONT) ? go : (go & ~go_q);

  assign ro_edge  = s2_q & ~s3_q;
  assign cnt_en   = (state_q == COUNT);
  assign win_end  = (wcnt_q == win_q - WINDOW_WIDTH'(1));
  assign sum_end  = (state_q == SUM) && (scnt_q == SUM_LAST);
  assign more_win = (idx_q != ns_q);
  assign cnt_clr  = (state_q == ARM) || (sum_end && more_win);

  // Input synchronisers run in every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= ro_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_clr) begin
      for (int i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (cnt_en) begin
      for (int i = 0; i < N; i++) begin
        if (ro_edge[i] && cnt_q[i] != CNT_MAX) begin
          cnt_q[i] <= cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  always_comb begin
    tree_in = '0;
    for (int i = 0; i < N; i++) begin
      tree_in[i*WIDTH +: WIDTH] = mask_q[i] ? cnt_q[i] : '0;
    end
  end

  // Counters are stable through SUM, so only the first SUM cycle
  // needs to be tagged valid.
  assign tree_in_vld = (state_q == SUM) && (scnt_q == '0);

  ro_add_tree #(
    .N    (N),
    .WIDTH(WIDTH)
  ) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_i      (tree_in),
    .in_valid_i(tree_in_vld),
    .sum_o     (tree_sum),
    .valid_o   (tree_vld)
  );

  // The tree result lands in the cycle after SUM (PUSH or the next
  // COUNT), so PUSH stores the accumulator including that last sum.
  assign acc_d = acc_q + (tree_vld ? ACC_WIDTH'(tree_sum) : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (state_q == ARM) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty = (wptr_q == rptr_q);
  assign push  = (state_q == PUSH);
  assign pop   = ~empty & result_ready;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wptr_q[AW-1:0]] <= acc_d;
        wptr_q <= wptr_q + (AW+1)'(1);
      end
      if (pop) begin
        rptr_q <= rptr_q + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      mode_q  <= RO_MODE_SINGLE;
      ns_q    <= '0;
      idx_q   <= '0;
      win_q   <= WINDOW_WIDTH'(1);
      wcnt_q  <= '0;
      scnt_q  <= '0;
      mask_q  <= '0;
    end else begin
      go_q <= go;
      unique case (state_q)
        IDLE: begin
          if (go_start) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
            ovf_q   <= 1'b0;
          end
        end
        ARM: begin
          mode_q  <= mode;
          ns_q    <= num_samples;
          mask_q  <= ch_mask;
          win_q   <= (window_cycles == '0) ?
                     WINDOW_WIDTH'(1) : window_cycles;
          idx_q   <= '0;
          wcnt_q  <= '0;
          scnt_q  <= '0;
          state_q <= COUNT;
        end
        COUNT: begin
          if (win_end) begin
            wcnt_q  <= '0;
            scnt_q  <= '0;
            state_q <= SUM;
          end else begin
            wcnt_q <= wcnt_q + WINDOW_WIDTH'(1);
          end
        end
        SUM: begin
          if (sum_end) begin
            if (more_win) begin
              idx_q   <= idx_q + NUM_SAMPLE_WIDTH'(1);
              state_q <= COUNT;
            end else begin
              state_q <= PUSH;
            end
          end else begin
            scnt_q <= scnt_q + SCW'(1);
          end
        end
        PUSH: begin
          if (drop) begin
            ovf_q <= 1'b1;
          end
          if (mode_q == RO_MODE_CONT && go) begin
            state_q <= ARM;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RO_SAT_FLAG_EN
  logic [N-1:0] sat_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_q <= '0;
    end else if (state_q == IDLE && go_start) begin
      sat_q <= '0;
    end else if (cnt_en) begin
      for (int i = 0; i < N; i++) begin
        if (ro_edge[i] && cnt_q[i] >= CNT_MAX - WIDTH'(1)) begin
          sat_q[i] <= 1'b1;
        end
      end
    end
  end

  assign ch_sat = sat_q;
`endif

  assign result       = mem_q[rptr_q[AW-1:0]];
  assign result_valid = ~empty;
  assign busy         = busy_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_ro_sense_ctrl.sv
// tb_ro_sense_ctrl: randomized bench for ro_sense_ctrl against a window-count model.
// Instantiates a default build and a WIDTH=4 build sharing all inputs.
module tb_ro_sense_ctrl;

  localparam int N    = 8;
  localparam int W    = 16;
  localparam int NSW  = 3;
  localparam int WW   = 16;
  localparam int FD   = 4;
  localparam int L    = 3;
  localparam int ACC  = W + L + NSW;
  localparam int W4   = 4;
  localparam int ACC4 = W4 + L + NSW;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic           go = 1'b0;
  logic           mode = 1'b0;
  logic           result_ready = 1'b0;
  logic [NSW-1:0] num_samples = '0;
  logic [WW-1:0]  window_cycles = 16'd100;
  logic [N-1:0]   ch_mask = '1;
  logic [N-1:0]   ro_in = '0;

  logic [ACC-1:0]  result;
  logic            result_valid;
  logic            busy;
  logic            overflow;
  logic [ACC4-1:0] result4;
  logic            valid4;
  logic            busy4;
  logic            ovf4;
`ifdef RO_SAT_FLAG_EN
  logic [N-1:0]    ch_sat;
  logic [N-1:0]    ch_sat4;
`endif

  int checks = 0;
  int errors = 0;
  int tcnt = 0;
  int half [N];
  int ph [N];

  always #5 clk = ~clk;

  ro_sense_ctrl #(
    .N(N), .WIDTH(W), .NUM_SAMPLE_WIDTH(NSW),
    .WINDOW_WIDTH(WW), .FIFO_DEPTH(FD)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .num_samples(num_samples), .window_cycles(window_cycles),
    .ch_mask(ch_mask), .ro_in(ro_in), .result(result),
    .result_valid(result_valid), .result_ready(result_ready),
    .busy(busy), .overflow(overflow)
`ifdef RO_SAT_FLAG_EN
    , .ch_sat(ch_sat)
`endif
  );

  ro_sense_ctrl #(
    .N(N), .WIDTH(W4), .NUM_SAMPLE_WIDTH(NSW),
    .WINDOW_WIDTH(WW), .FIFO_DEPTH(FD)
  ) u_sat (
    .clk(clk), .rst_n(rst_n), .go(go), .mode(mode),
    .num_samples(num_samples), .window_cycles(window_cycles),
    .ch_mask(ch_mask), .ro_in(ro_in), .result(result4),
    .result_valid(valid4), .result_ready(result_ready),
    .busy(busy4), .overflow(ovf4)
`ifdef RO_SAT_FLAG_EN
    , .ch_sat(ch_sat4)
`endif
  );

  // Channel c is a square wave with half-period half[c] cycles
  // (0 = held low), indexed by the clock edge that samples it.
  function automatic bit wave(int c, int s);
    if (half[c] == 0) return 1'b0;
    return (((s + ph[c]) / half[c]) % 2) == 1;
  endfunction

  // Window k sees the rising edges sampled at edges
  // g + k*(w+L) .. g + k*(w+L) + w - 1, where g samples go.
  function automatic longint model(int g, int win, int ns,
                                   logic [N-1:0] mask, int wid);
    longint acc = 0;
    longint mx = (longint'(1) << wid) - 1;
    int w = (win == 0) ? 1 : win;
    for (int k = 0; k <= ns; k++) begin
      int base = g + k * (w + L);
      for (int c = 0; c < N; c++) begin
        longint e = 0;
        if (mask[c]) begin
          for (int s = base; s < base + w; s++) begin
            if (wave(c, s) && !wave(c, s - 1)) e++;
          end
          if (e > mx) e = mx;
          acc += e;
        end
      end
    end
    return acc;
  endfunction

  task automatic tick();
    for (int c = 0; c < N; c++) ro_in[c] = wave(c, tcnt);
    @(posedge clk);
    tcnt++;
    #1;
  endtask

  task automatic set_all(input int h);
    for (int c = 0; c < N; c++) begin
      half[c] = h;
      ph[c] = $urandom_range(0, 7);
    end
  endtask

  task automatic pop();
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
  endtask

  task automatic run_single(input int win, input int ns,
                            input logic [N-1:0] mask,
                            output int g, output int seen);
    int n = 0;
    mode = 1'b0;
    window_cycles = WW'(win);
    num_samples = NSW'(ns);
    ch_mask = mask;
    go = 1'b0;
    tick();
    go = 1'b1;
    g = tcnt;
    tick();
    go = 1'b0;
    while (!result_valid && n < 3000) begin
      tick();
      n++;
    end
    seen = result_valid ? tcnt : -1;
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL run_timeout result_valid=%b required 1", result_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (result !== '0) begin
      errors++;
      $display("FAIL rst_result got %0d required 0", result);
    end
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_valid got %b required 0", result_valid);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_busy got %b required 0", busy);
    end
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL rst_ovf got %b required 0", overflow);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_basic();
    int g, seen;
    set_all(2);
    run_single(100, 0, 8'hFF, g, seen);
    checks += 3;
    if (result !== 200) begin
      errors++;
      $display("FAIL basic_result got %0d required 200", result);
    end
    if (seen !== g + 100 + L + 3) begin
      errors++;
      $display("FAIL basic_latency got %0d required %0d",
               seen - g, 100 + L + 3);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy got %b required 0", busy);
    end
    pop();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_pop_valid got %b required 0", result_valid);
    end
  endtask

  task automatic test_multi();
    int g, seen;
    set_all(2);
    run_single(100, 7, 8'hFF, g, seen);
    checks++;
    if (result !== 1600) begin
      errors++;
      $display("FAIL multi_result got %0d required 1600", result);
    end
    pop();
  endtask

  task automatic test_mask();
    int g, seen;
    logic [ACC-1:0] exp [2];
    logic [N-1:0] m [2];
    exp[0] = 100;
    exp[1] = 0;
    m[0] = 8'h0F;
    m[1] = 8'h00;
    for (int i = 0; i < 2; i++) begin
      set_all(2);
      run_single(100, 0, m[i], g, seen);
      checks++;
      if (result !== exp[i]) begin
        errors++;
        $display("FAIL mask_%h got %0d required %0d",
                 m[i], result, exp[i]);
      end
      pop();
    end
  endtask

  task automatic test_random();
    int g, seen, win, ns;
    logic [N-1:0] mask;
    longint exp;
    for (int it = 0; it < 8; it++) begin
      for (int c = 0; c < N; c++) begin
        half[c] = $urandom_range(0, 4);
        ph[c] = $urandom_range(0, 7);
      end
      win = (it == 0) ? 0 : $urandom_range(1, 40);
      ns = $urandom_range(0, 7);
      mask = N'($urandom);
      run_single(win, ns, mask, g, seen);
      exp = model(g, win, ns, mask, W);
      checks++;
      if (result !== ACC'(exp)) begin
        errors++;
        $display("FAIL rand%0d w=%0d ns=%0d m=%h got %0d required %0d",
                 it, win, ns, mask, result, exp);
      end
      pop();
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    int g, seen;
    set_all(2);
    window_cycles = 16'd100;
    num_samples = '0;
    ch_mask = 8'hFF;
    mode = 1'b1;
    go = 1'b1;
    while (overflow !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    go = 1'b0;
    n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    checks += 3;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flag got %b required 1", overflow);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ovf_busy got %b required 0", busy);
    end
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_valid got %b required 1", result_valid);
    end
    for (int i = 0; i < FD; i++) begin
      checks += 2;
      if (result_valid !== 1'b1) begin
        errors++;
        $display("FAIL ovf_pop%0d_valid got %b required 1",
                 i, result_valid);
      end
      if (result !== 200) begin
        errors++;
        $display("FAIL ovf_pop%0d got %0d required 200", i, result);
      end
      pop();
    end
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_drained got %b required 0", result_valid);
    end
    run_single(100, 0, 8'hFF, g, seen);
    checks += 2;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_clear got %b required 0", overflow);
    end
    if (result !== 200) begin
      errors++;
      $display("FAIL ovf_rerun got %0d required 200", result);
    end
    pop();
  endtask

  task automatic test_reset_mid();
    int g, seen;
    set_all(2);
    run_single(100, 0, 8'hFF, g, seen);
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (40) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy got %b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    checks += 4;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_valid got %b required 0", result_valid);
    end
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_busy got %b required 0", busy);
    end
    if (result !== '0) begin
      errors++;
      $display("FAIL mid_result got %0d required 0", result);
    end
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL mid_ovf got %b required 0", overflow);
    end
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    run_single(100, 0, 8'hFF, g, seen);
    checks++;
    if (result !== 200) begin
      errors++;
      $display("FAIL mid_rerun got %0d required 200", result);
    end
    pop();
  endtask

  task automatic test_sat();
    int g, seen;
    result_ready = 1'b1;
    repeat (6) tick();
    result_ready = 1'b0;
    for (int c = 0; c < N; c++) begin
      half[c] = 0;
      ph[c] = 0;
    end
    half[0] = 1;
    run_single(100, 0, 8'hFF, g, seen);
    checks += 3;
    if (result !== 50) begin
      errors++;
      $display("FAIL sat_wide got %0d required 50", result);
    end
    if (valid4 !== 1'b1) begin
      errors++;
      $display("FAIL sat_valid4 got %b required 1", valid4);
    end
    if (result4 !== 15) begin
      errors++;
      $display("FAIL sat_narrow got %0d required 15", result4);
    end
`ifdef RO_SAT_FLAG_EN
    checks += 2;
    if (ch_sat4 !== 8'h01) begin
      errors++;
      $display("FAIL sat_flag4 got %h required 01", ch_sat4);
    end
    if (ch_sat !== 8'h00) begin
      errors++;
      $display("FAIL sat_flag got %h required 00", ch_sat);
    end
`endif
    pop();
  endtask

  initial begin
    for (int c = 0; c < N; c++) begin
      half[c] = 0;
      ph[c] = 0;
    end
    test_reset();
    test_basic();
    test_multi();
    test_mask();
    test_random();
    test_overflow();
    test_reset_mid();
    test_sat();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
